// File: rtl/regfile_pkg.sv
// Shared constants and the write-back request type for the register-file
// write-back path.
package regfile_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int NUM_REGS     = 32;
    localparam int DEFAULT_XLEN = 64;

    typedef struct packed {
        logic                    valid;
        logic [REG_IDX_W-1:0]    rd;
        logic [DEFAULT_XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin search: the requester named by ptr has top
// priority and the search wraps upward modulo N.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] grant
);

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter with a registered register-file write port
// and an optional pending-write scoreboard (enabled by WB_SCOREBOARD_EN).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = DEFAULT_XLEN
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*REG_IDX_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]     req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        reg_write,
    output logic [REG_IDX_W-1:0]        rd,
    output logic [XLEN-1:0]             WriteData,
    input  logic                        issue_valid,
    input  logic [REG_IDX_W-1:0]        issue_rd,
    input  logic [REG_IDX_W-1:0]        rs1,
    input  logic [REG_IDX_W-1:0]        rs2,
    output logic                        rs1_busy,
    output logic                        rs2_busy
);

    // Handshake: requester i transfers in any cycle where req_valid[i] and
    // req_ready[i] are both high; it must hold valid/rd/data until then.
    logic [1:0]           ptr;
    logic [NUM_REQ-1:0]   grant;
    logic                 fire;
    logic [1:0]           sel_idx;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]      sel_data;
    logic [1:0]           ptr_next;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid & {NUM_REQ{reset}}),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = grant;
    assign fire      = |grant;

    always_comb begin
        sel_idx  = '0;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx  = 2'(i);
                sel_rd   = req_rd[i*REG_IDX_W +: REG_IDX_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign ptr_next = (sel_idx == 2'(NUM_REQ - 1)) ? 2'd0 : sel_idx + 2'd1;

    // Writes to x0 still consume the grant but never reach the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            reg_write <= 1'b0;
            rd        <= '0;
            WriteData <= '0;
        end else begin
            reg_write <= fire && (sel_rd != '0);
            if (fire) begin
                ptr       <= ptr_next;
                rd        <= sel_rd;
                WriteData <= sel_data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_rd != '0) set_vec[issue_rd] = 1'b1;
        if (fire && sel_rd != '0)          clr_vec[sel_rd]   = 1'b1;
    end

    // Set wins over clear so a re-issued register stays pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
        end
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_rd, rs1, rs2};
    assign rs1_busy = 1'b0;
    assign rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NUM_REQ=3, XLEN=64); scoreboard
// expectations follow WB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 64;
`ifdef WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic                         clk;
    logic                         reset;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*REG_IDX_W-1:0] req_rd;
    logic [NUM_REQ*XLEN-1:0]      req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         reg_write;
    logic [REG_IDX_W-1:0]         rd;
    logic [XLEN-1:0]              WriteData;
    logic                         issue_valid;
    logic [REG_IDX_W-1:0]         issue_rd;
    logic [REG_IDX_W-1:0]         rs1;
    logic [REG_IDX_W-1:0]         rs2;
    logic                         rs1_busy;
    logic                         rs2_busy;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];
    wb_req_t         vec[NUM_REQ];

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .reg_write   (reg_write),
        .rd          (rd),
        .WriteData   (WriteData),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_req(input int i, input logic v, input logic [4:0] r, input logic [XLEN-1:0] d);
        req_valid[i]                          = v;
        req_rd[i*REG_IDX_W +: REG_IDX_W]      = r;
        req_data[i*XLEN +: XLEN]              = d;
    endtask

    task automatic idle_reqs();
        for (int i = 0; i < NUM_REQ; i++) drive_req(i, 1'b0, 5'd0, '0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;
        idle_reqs();
        req_valid = 3'b111;
        #12;
        check_eq("rst_ready", req_ready, 3'b000);
        check_eq("rst_reg_write", reg_write, 1'b0);
        check_eq("rst_rd", rd, 5'd0);
        check_eq("rst_wdata", WriteData, '0);
        idle_reqs();
        reset = 1'b1;
        tick();

        // single requester
        drive_req(1, 1'b1, 5'd5, 64'hAB);
        #1;
        check_eq("single_ready", req_ready, 3'b010);
        tick();
        idle_reqs();
        check_eq("single_we", reg_write, 1'b1);
        check_eq("single_rd", rd, 5'd5);
        check_eq("single_wdata", WriteData, 64'hAB);
        tick();
        check_eq("idle_we", reg_write, 1'b0);
        check_eq("idle_rd_hold", rd, 5'd5);
        check_eq("idle_wdata_hold", WriteData, 64'hAB);

        // contention from reset: grant order 0,1,2,0,1,2
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            vec[i] = '{valid: 1'b1, rd: 5'(i + 1), data: 64'h1000 + 64'(i)};
            drive_req(i, vec[i].valid, vec[i].rd, vec[i].data);
        end
        for (int n = 0; n < 6; n++) exp_q.push_back(XLEN'(1 << (n % 3)));
        for (int n = 0; n < 6; n++) begin
            logic [XLEN-1:0] exp_g;
            exp_g = exp_q.pop_front();
            #1;
            check_eq($sformatf("rr_grant%0d", n), req_ready, exp_g);
            tick();
            check_eq($sformatf("rr_rd%0d", n), rd, vec[n % 3].rd);
            check_eq($sformatf("rr_wdata%0d", n), WriteData, vec[n % 3].data);
        end
        idle_reqs();
        tick();

        // scoreboard: issue rd=7 (and rd=0, which must never mark busy)
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_rd    = 5'd0;
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd7;
        rs2 = 5'd0;
        #1;
        check_eq("sb_set", rs1_busy, SB);
        check_eq("sb_x0_never_busy", rs2_busy, 1'b0);

        // x0 write on requester 0 (pointer is 0 after the contention run)
        drive_req(0, 1'b1, 5'd0, 64'h55);
        #1;
        check_eq("x0_ready", req_ready, 3'b001);
        tick();
        idle_reqs();
        check_eq("x0_we", reg_write, 1'b0);
        check_eq("x0_busy_unchanged", rs1_busy, SB);

        // write-back to 7 on requester 1 clears busy
        drive_req(1, 1'b1, 5'd7, 64'h77);
        rs2 = 5'd3;
        #1;
        check_eq("wb7_ready", req_ready, 3'b010);
        tick();
        idle_reqs();
        check_eq("wb7_we", reg_write, 1'b1);
        check_eq("wb7_rd", rd, 5'd7);
        check_eq("sb_clear", rs1_busy, 1'b0);
        check_eq("sb_rs2_idle", rs2_busy, 1'b0);

        // issue and write-back to 7 in the same cycle: stays busy
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        drive_req(2, 1'b1, 5'd7, 64'h99);
        #1;
        check_eq("both_ready", req_ready, 3'b100);
        tick();
        issue_valid = 1'b0;
        idle_reqs();
        check_eq("both_we", reg_write, 1'b1);
        check_eq("sb_set_wins", rs1_busy, SB);

        // reset mid-stream: transfer on 0 (ptr -> 1), then reset during grant on 1
        drive_req(0, 1'b1, 5'd9, 64'hC0);
        #1;
        check_eq("pre_rst_ready0", req_ready, 3'b001);
        tick();
        idle_reqs();
        drive_req(1, 1'b1, 5'd10, 64'hC1);
        #1;
        check_eq("pre_rst_ready1", req_ready, 3'b010);
        #1;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_ready", req_ready, 3'b000);
        check_eq("mid_rst_we", reg_write, 1'b0);
        check_eq("mid_rst_rd", rd, 5'd0);
        check_eq("mid_rst_wdata", WriteData, '0);
        check_eq("mid_rst_busy", rs1_busy, 1'b0);
        tick();
        idle_reqs();
        reset = 1'b1;
        tick();
        check_eq("post_rst_we", reg_write, 1'b0);
        check_eq("post_rst_busy", rs1_busy, 1'b0);
        req_valid = 3'b111;
        #1;
        check_eq("post_rst_ptr0", req_ready, 3'b001);
        idle_reqs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
